// File: rtl/cpu_pkg.sv
// Shared loader types: FSM state encoding, frame field layout and checksum width.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_t;

    localparam int BYTE_W     = 8;
    localparam int CSUM_W     = 8;
    localparam int LEN_W      = 16;
    localparam int LEN_HI_LSB = 8;
    localparam int LEN_LO_LSB = 0;
    localparam int WORD_BYTES = 4;
    localparam int INSTR_W    = BYTE_W * WORD_BYTES;

    // States in which a frame is being received and the core must be held.
    function automatic logic is_busy(input ld_state_t st);
        return (st == ST_LEN_HI) || (st == ST_LEN_LO) || (st == ST_DATA) || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle counter: expires when LIMIT enabled cycles pass without a clear.
module loader_timeout
    import cpu_pkg::*;
#(
    parameter int LIMIT = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_W'(LIMIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires on the edge that would bring the count to LIMIT; a same-cycle clear wins.
    assign expired = enable && !clear && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: assembles big-endian words from a byte stream, writes
// them into instruction memory and holds the core in reset until the frame verifies.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int MAX_WORDS      = 16384,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                rx_valid,
    input  logic [BYTE_W-1:0]   rx_byte,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [INSTR_W-1:0]  imem_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     word_count
);

    ld_state_t state, state_next;

    logic [BYTE_W-1:0]          len_hi;
    logic [LEN_W-1:0]           len;
    logic [INSTR_W-BYTE_W-1:0]  word_sr;
    logic [1:0]                 byte_idx;
    logic [CSUM_W-1:0]          csum;

    logic                       busy;
    logic                       start_go;
    logic                       data_acc;
    logic                       word_fill;
    logic                       last_word;
    logic [LEN_W-1:0]           len_rx;
    logic [INSTR_W-1:0]         word_next;
    logic [31:0]                wc_next;
    logic                       tmo_clear;
    logic                       tmo_expired;

    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [BYTE_W-1:0] b);
        return acc + CSUM_W'(b);
    endfunction

    assign busy      = is_busy(state);
    assign start_go  = start && !busy;
    assign data_acc  = (state == ST_DATA) && rx_valid;
    assign word_fill = data_acc && (byte_idx == 2'd3);
    assign len_rx    = (LEN_W'(len_hi) << LEN_HI_LSB) | (LEN_W'(rx_byte) << LEN_LO_LSB);
    assign word_next = {word_sr, rx_byte};
    assign wc_next   = 32'(word_count) + 32'd1;
    assign last_word = word_fill && (wc_next == 32'(len));

    // Counter sits at zero whenever no frame is in flight.
    assign tmo_clear = !busy || rx_valid;

    loader_timeout #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (busy),
        .expired (tmo_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    state_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    if ((len_rx == '0) || (int'(len_rx) > MAX_WORDS)) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (last_word) begin
                    state_next = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    state_next = (rx_byte == csum) ? ST_DONE : ST_ERR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (tmo_expired) begin
            state_next = ST_ERR;
        end
    end

    assign cpu_hold = (state != ST_IDLE) && (state != ST_DONE);
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERR);

    // Control and write-port registers; a reset mid-word drops the partial word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            byte_idx   <= '0;
            csum       <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_go) begin
                word_count <= '0;
                byte_idx   <= '0;
                csum       <= '0;
            end
            if (data_acc) begin
                csum     <= csum_add(csum, rx_byte);
                byte_idx <= byte_idx + 2'd1;
            end
            if (word_fill) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= word_next;
                word_count <= word_count + (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if ((state == ST_LEN_HI) && rx_valid) begin
            len_hi <= rx_byte;
        end
        if ((state == ST_LEN_LO) && rx_valid) begin
            len <= len_rx;
        end
        if (data_acc) begin
            word_sr <= word_next[INSTR_W-BYTE_W-1:0];
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with hand-computed expectations.
module tb_imem_loader;

    localparam int ADDR_W = 14;

    logic              clock;
    logic              reset;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    int vectors    = 0;
    int miscompares = 0;
    int we_cnt     = 0;
    int snap;

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .MAX_WORDS      (16384),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (imem_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic s);
        @(negedge clock);
        rx_valid = v;
        rx_byte  = b;
        start    = s;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},    32'(imem_we), 32'd0);
        chk({tag, "_addr"},  32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_hold"},  32'(cpu_hold), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_err"},   32'(error), 32'd0);
        chk({tag, "_wc"},    32'(word_count), 32'd0);
    endtask

    // Two-word frame 00 02 24 08 00 05 00 00 00 0C <cs>; start also pulsed on byte start_at.
    task automatic load_frame(input string tag, input logic [7:0] cs, input int start_at);
        logic [7:0] fr [0:10];
        fr = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00};
        fr[10] = cs;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, fr[i], i == start_at);
            if (i == 3) chk({tag, "_hold_mid"}, 32'(cpu_hold), 32'd1);
            if (i == 4) chk({tag, "_we_idle"}, 32'(imem_we), 32'd0);
            if (i == 5) begin
                chk({tag, "_w0_we"},   32'(imem_we), 32'd1);
                chk({tag, "_w0_addr"}, 32'(imem_addr), 32'd0);
                chk({tag, "_w0_data"}, imem_wdata, 32'h24080005);
                chk({tag, "_w0_wc"},   32'(word_count), 32'd1);
            end
            if (i == 6) chk({tag, "_w0_pulse"}, 32'(imem_we), 32'd0);
            if (i == 9) begin
                chk({tag, "_w1_we"},   32'(imem_we), 32'd1);
                chk({tag, "_w1_addr"}, 32'(imem_addr), 32'd1);
                chk({tag, "_w1_data"}, imem_wdata, 32'h0000000C);
                chk({tag, "_w1_wc"},   32'(word_count), 32'd2);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_vals("rst");
        @(negedge clock);
        reset = 1'b1;

        // Good two-word load
        step(1'b0, 8'h00, 1'b1);
        chk("t1_start_hold", 32'(cpu_hold), 32'd1);
        load_frame("t1", 8'h3D, -1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_err", 32'(error), 32'd0);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_wc", 32'(word_count), 32'd2);
        step(1'b1, 8'h77, 1'b0);
        chk("t1_done_held", 32'(done), 32'd1);
        chk("t1_wc_held", 32'(word_count), 32'd2);

        // Bad checksum
        step(1'b0, 8'h00, 1'b1);
        chk("t2_start_done", 32'(done), 32'd0);
        chk("t2_start_wc", 32'(word_count), 32'd0);
        load_frame("t2", 8'h3E, -1);
        chk("t2_err", 32'(error), 32'd1);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_hold", 32'(cpu_hold), 32'd1);

        // Zero length, then length just above the maximum
        step(1'b0, 8'h00, 1'b1);
        chk("t3_start_err", 32'(error), 32'd0);
        snap = we_cnt;
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("t3_zero_err", 32'(error), 32'd1);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        chk("t3_ignored_err", 32'(error), 32'd1);
        chk("t3_ignored_wc", 32'(word_count), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("t3_no_write", 32'(we_cnt), 32'(snap));
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        chk("t3_toolong_err", 32'(error), 32'd1);

        // Timeout after the second data byte
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            step(1'b0, 8'h00, 1'b0);
            if (j == 15) chk("t4_err_at15", 32'(error), 32'd0);
            if (j == 16) chk("t4_err_at16", 32'(error), 32'd1);
        end
        chk("t4_hold", 32'(cpu_hold), 32'd1);

        // Byte on the limit cycle keeps the load alive
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        repeat (15) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        chk("t4b_err", 32'(error), 32'd0);
        step(1'b1, 8'h44, 1'b0);
        chk("t4b_we", 32'(imem_we), 32'd1);
        chk("t4b_data", imem_wdata, 32'h11223344);
        step(1'b1, 8'hAA, 1'b0);
        chk("t4b_done", 32'(done), 32'd1);

        // Reset mid-word
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h24, 1'b0);
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("t5_pre_hold", 32'(cpu_hold), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("t5_async");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        load_frame("t5", 8'h3D, -1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_wc", 32'(word_count), 32'd2);

        // Spurious rx_valid in IDLE and start mid-DATA
        #2;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        snap = we_cnt;
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h24, 1'b0);
        chk("t6_idle_hold", 32'(cpu_hold), 32'd0);
        chk("t6_idle_done", 32'(done), 32'd0);
        chk("t6_idle_wc", 32'(word_count), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        chk("t6_idle_nowrite", 32'(we_cnt), 32'(snap));
        step(1'b0, 8'h00, 1'b1);
        load_frame("t6", 8'h3D, 4);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_hold", 32'(cpu_hold), 32'd0);
        chk("t6_wc", 32'(word_count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
